// File: rtl/pipe_perf_monitor.sv
// Performance event counters for the pipelined core, with a tear-free snapshot port.
// Optional watchdog halt: define PERF_WATCHDOG_EN to enable it (limit set by MAX_CYCLES).
module pipe_perf_monitor #(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             retire_i,
    input  logic             halt_i,
    input  logic             clear_i,
    input  logic             snap_req_i,
    input  logic             snap_ack_i,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [3:0]       ovf_o,
    output logic             snap_valid_o,
    output logic [CNT_W-1:0] snap_cycle_o,
    output logic [CNT_W-1:0] snap_stall_o,
    output logic [CNT_W-1:0] snap_flush_o,
    output logic [CNT_W-1:0] snap_retire_o,
    output logic             timeout_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic             start_d;
    logic             rise;
    logic             running;
    logic             wd_hit;
    logic [3:0]       inc;
    logic [CNT_W-1:0] cnt [4];

    assign rise    = start_i & ~start_d;
    assign running = (state == RUN);
    // Counter order matches ovf_o bit order: {retire, flush, stall, cycle}.
    assign inc     = {retire_i, flush_i, stall_i, 1'b1};

`ifdef PERF_WATCHDOG_EN
    // Compare at 64 bits so a MAX_CYCLES beyond the counter range simply never fires.
    localparam logic [63:0] WD_LAST = 64'(MAX_CYCLES) - 64'd1;
    logic timeout_q;

    assign wd_hit    = running && (64'(cnt[0]) == WD_LAST);
    assign timeout_o = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timeout_q <= 1'b0;
        else if (clear_i)
            timeout_q <= 1'b0;
        else if (wd_hit)
            timeout_q <= 1'b1;
    end
`else
    logic unused_max_cycles;

    assign unused_max_cycles = (MAX_CYCLES != 0);
    assign wd_hit            = 1'b0;
    assign timeout_o         = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            start_d <= 1'b0;
        else
            start_d <= start_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (clear_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) state <= RUN;
                RUN:     if (halt_i || wd_hit) state <= HALTED;
                HALTED:  state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating counters; the sticky ovf bit records an increment lost at the ceiling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            ovf_o <= 4'b0;
        end else if (clear_i) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            ovf_o <= 4'b0;
        end else if (running) begin
            for (int i = 0; i < 4; i++) begin
                if (inc[i]) begin
                    if (cnt[i] == CNT_MAX)
                        ovf_o[i] <= 1'b1;
                    else
                        cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Handshake: capture when req seen with no valid snapshot; ack while valid releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_valid_o  <= 1'b0;
            snap_cycle_o  <= '0;
            snap_stall_o  <= '0;
            snap_flush_o  <= '0;
            snap_retire_o <= '0;
        end else if (!snap_valid_o) begin
            if (snap_req_i) begin
                snap_valid_o  <= 1'b1;
                snap_cycle_o  <= cnt[0];
                snap_stall_o  <= cnt[1];
                snap_flush_o  <= cnt[2];
                snap_retire_o <= cnt[3];
            end
        end else if (snap_ack_i) begin
            snap_valid_o <= 1'b0;
        end
    end

    assign state_o      = state;
    assign cycle_cnt_o  = cnt[0];
    assign stall_cnt_o  = cnt[1];
    assign flush_cnt_o  = cnt[2];
    assign retire_cnt_o = cnt[3];
endmodule
